mem_arbiter: RTL and testbench

Shares the single word-level port of the byte-serial RAM controller between three requesters: instruction fetch (IF), the load unit (LD) and store-buffer commit (ST). Grants one request at a time, holds it on the controller port until the controller reports completion, and routes the done pulse and read data back to the owner. Handles pipeline flush by draining and discarding in-flight fetches. It also bounds instruction-fetch starvation with an aging counter.

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the RAM controller's single word port between fetch, load and store.
// One transaction at a time; a flushed fetch is drained and its result discarded.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_len,
  input  logic        ld_signed,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_len,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_signed,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_len,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data,
  input  logic        mem_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} owner_t;

  localparam logic [1:0] LEN_WORD = 2'b11;

  state_t             state, state_nxt;
  owner_t             owner, owner_nxt, winner;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_nxt;
  logic               if_elig, ld_elig, st_elig, if_starved;

  logic               mem_read_nxt, mem_write_nxt, mem_signed_nxt;
  logic [31:0]        mem_addr_nxt, mem_w_data_nxt;
  logic [1:0]         mem_len_nxt;
  logic               if_done_nxt, ld_done_nxt, st_done_nxt;
  logic [31:0]        if_data_nxt, ld_data_nxt;

  // A requester whose done pulse is out this cycle still shows the old req; mask it.
  assign if_elig    = if_req & ~if_done & ~flush;
  assign ld_elig    = ld_req & ~ld_done;
  assign st_elig    = st_req & ~st_done;
  assign if_starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    winner = OWN_NONE;
    if (if_elig && if_starved) winner = OWN_IF;
    else if (st_elig)          winner = OWN_ST;
    else if (ld_elig)          winner = OWN_LD;
    else if (if_elig)          winner = OWN_IF;
  end

  // State register; every output is registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_signed <= 1'b0;
      mem_addr   <= '0;
      mem_len    <= '0;
      mem_w_data <= '0;
      if_done    <= 1'b0;
      if_data    <= '0;
      ld_done    <= 1'b0;
      ld_data    <= '0;
      st_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_cnt_nxt;
      mem_read   <= mem_read_nxt;
      mem_write  <= mem_write_nxt;
      mem_signed <= mem_signed_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_len    <= mem_len_nxt;
      mem_w_data <= mem_w_data_nxt;
      if_done    <= if_done_nxt;
      if_data    <= if_data_nxt;
      ld_done    <= ld_done_nxt;
      ld_data    <= ld_data_nxt;
      st_done    <= st_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (winner != OWN_NONE) begin
          state_nxt = BUSY;
          owner_nxt = winner;
        end
      end
      BUSY: begin
        if (mem_done) begin
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
        end else if (flush && owner == OWN_IF) begin
          // The controller cannot abort, so the fetch runs out with its result dropped.
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_done) begin
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_comb begin
    mem_read_nxt   = mem_read;
    mem_write_nxt  = mem_write;
    mem_signed_nxt = mem_signed;
    mem_addr_nxt   = mem_addr;
    mem_len_nxt    = mem_len;
    mem_w_data_nxt = mem_w_data;
    if_done_nxt    = 1'b0;
    ld_done_nxt    = 1'b0;
    st_done_nxt    = 1'b0;
    if_data_nxt    = if_data;
    ld_data_nxt    = ld_data;
    starve_cnt_nxt = starve_cnt;

    case (state)
      IDLE: begin
        case (winner)
          OWN_IF: begin
            mem_read_nxt   = 1'b1;
            mem_addr_nxt   = if_addr;
            mem_len_nxt    = LEN_WORD;
            mem_signed_nxt = 1'b0;
            mem_w_data_nxt = '0;
          end
          OWN_LD: begin
            mem_read_nxt   = 1'b1;
            mem_addr_nxt   = ld_addr;
            mem_len_nxt    = ld_len;
            mem_signed_nxt = ld_signed;
            mem_w_data_nxt = '0;
          end
          OWN_ST: begin
            mem_write_nxt  = 1'b1;
            mem_addr_nxt   = st_addr;
            mem_len_nxt    = st_len;
            mem_signed_nxt = 1'b0;
            mem_w_data_nxt = st_data;
          end
          default: ;
        endcase
        if (winner == OWN_IF)
          starve_cnt_nxt = '0;
        else if (winner != OWN_NONE && if_elig && !(&starve_cnt))
          starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
      BUSY: begin
        if (mem_done) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          case (owner)
            OWN_IF: begin
              if (!flush) begin
                if_done_nxt = 1'b1;
                if_data_nxt = mem_r_data;
              end
            end
            OWN_LD: begin
              ld_done_nxt = 1'b1;
              ld_data_nxt = mem_r_data;
            end
            OWN_ST:  st_done_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      DRAIN: begin
        if (mem_done) mem_read_nxt = 1'b0;
      end
      default: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
      end
    endcase

    if (flush) starve_cnt_nxt = '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, starvation sequence, then random
// traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req, ld_req, st_req, ld_signed;
  logic [31:0] if_addr, ld_addr, st_addr, st_data;
  logic [1:0]  ld_len, st_len;
  logic        if_done, ld_done, st_done;
  logic [31:0] if_data, ld_data;
  logic        mem_read, mem_write, mem_signed, mem_done;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic [1:0]  mem_len;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_signed(ld_signed),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data),
    .st_done(st_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .mem_done(mem_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: who owns the port, whether its result is to be thrown away,
  // and how many arbitrations fetch has lost in a row.
  int          m_owner;  // 0 none, 1 fetch, 2 load, 3 store
  bit          m_discard;
  int          m_losses;
  logic        e_read, e_write, e_signed, e_if_done, e_ld_done, e_st_done;
  logic [31:0] e_addr, e_wdata, e_if_data, e_ld_data;
  logic [1:0]  e_len;

  task automatic model_step();
    bit ie, le, se;
    int win;
    if (rst) begin
      m_owner = 0; m_discard = 0; m_losses = 0;
      {e_read, e_write, e_signed, e_if_done, e_ld_done, e_st_done} = '0;
      e_addr = '0; e_wdata = '0; e_if_data = '0; e_ld_data = '0; e_len = '0;
      return;
    end
    ie = if_req && !e_if_done && !flush;
    le = ld_req && !e_ld_done;
    se = st_req && !e_st_done;
    e_if_done = 0; e_ld_done = 0; e_st_done = 0;
    if (m_owner == 0) begin
      if (ie && m_losses >= STARVE_LIMIT) win = 1;
      else if (se) win = 3;
      else if (le) win = 2;
      else if (ie) win = 1;
      else win = 0;
      if (win != 0) begin
        m_owner = win;
        e_read  = (win != 3);
        e_write = (win == 3);
        if (win == 1) begin e_addr = if_addr; e_len = 2'b11; e_signed = 0; e_wdata = 0; end
        if (win == 2) begin e_addr = ld_addr; e_len = ld_len; e_signed = ld_signed; e_wdata = 0; end
        if (win == 3) begin e_addr = st_addr; e_len = st_len; e_signed = 0; e_wdata = st_data; end
        if (win == 1) m_losses = 0;
        else if (ie && m_losses < (1 << CNT_W) - 1) m_losses++;
      end
    end else if (mem_done) begin
      e_read = 0; e_write = 0;
      if (!m_discard && !(m_owner == 1 && flush)) begin
        if (m_owner == 1) begin e_if_done = 1; e_if_data = mem_r_data; end
        if (m_owner == 2) begin e_ld_done = 1; e_ld_data = mem_r_data; end
        if (m_owner == 3) e_st_done = 1;
      end
      m_owner = 0; m_discard = 0;
    end else if (m_owner == 1 && flush) begin
      m_discard = 1;
    end
    if (flush) m_losses = 0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  // Controller stand-in: answers each request after 0..maxlat extra cycles.
  int lat = 0;
  task automatic ctrl_step(int maxlat);
    if (mem_done || rst) mem_done = 1'b0;
    else if (mem_read || mem_write) begin
      if (lat == 0) begin
        mem_done   = 1'b1;
        mem_r_data = $urandom;
        lat        = $urandom_range(0, maxlat);
      end else lat--;
    end
  endtask

  typedef struct {
    logic        r, f, i, l, s, d;
    logic [31:0] rdat;
    logic        rd, wr;
    logic [31:0] addr;
    logic        ifd, ldd, std;
    logic [31:0] ifdat, lddat;
  } vec_t;

  function automatic vec_t v(logic r, f, i, l, s, d, logic [31:0] rdat,
                             logic rd, wr, logic [31:0] addr, logic ifd, ldd, std,
                             logic [31:0] ifdat, lddat);
    vec_t t;
    t.r = r; t.f = f; t.i = i; t.l = l; t.s = s; t.d = d; t.rdat = rdat;
    t.rd = rd; t.wr = wr; t.addr = addr; t.ifd = ifd; t.ldd = ldd; t.std = std;
    t.ifdat = ifdat; t.lddat = lddat;
    return t;
  endfunction

  vec_t        tbl[$];
  logic [31:0] grants[$];
  logic [31:0] exp_g[7];
  bit          prev_act;

  initial begin
    rst = 1; flush = 0; if_req = 0; ld_req = 0; st_req = 0; mem_done = 0; mem_r_data = 0;
    if_addr = 32'h40; ld_addr = 32'h100; ld_len = 2'b11; ld_signed = 0;
    st_addr = 32'h200; st_len = 2'b00; st_data = 32'h12345678;

    //             rst f i l s done rdata           rd wr addr    ifd ldd std if_data       ld_data
    tbl.push_back(v(1, 0,0,0,0, 0, 0,               0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0,0,1,0, 0, 0,               1, 0, 32'h100, 0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0,0,1,0, 0, 0,               1, 0, 32'h100, 0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0,0,1,0, 1, 32'hDEADBEEF,    0, 0, 32'h100, 0, 1, 0, 32'h0,        32'hDEADBEEF));
    tbl.push_back(v(0, 0,0,0,0, 0, 0,               0, 0, 32'h100, 0, 0, 0, 32'h0,        32'hDEADBEEF));
    tbl.push_back(v(0, 0,1,1,1, 0, 0,               0, 1, 32'h200, 0, 0, 0, 32'h0,        32'hDEADBEEF));
    tbl.push_back(v(0, 0,1,1,1, 1, 0,               0, 0, 32'h200, 0, 0, 1, 32'h0,        32'hDEADBEEF));
    tbl.push_back(v(0, 0,1,1,0, 0, 0,               1, 0, 32'h100, 0, 0, 0, 32'h0,        32'hDEADBEEF));
    tbl.push_back(v(0, 0,1,1,0, 1, 32'hCAFEF00D,    0, 0, 32'h100, 0, 1, 0, 32'h0,        32'hCAFEF00D));
    tbl.push_back(v(0, 0,1,0,0, 0, 0,               1, 0, 32'h40,  0, 0, 0, 32'h0,        32'hCAFEF00D));
    tbl.push_back(v(0, 0,1,0,0, 1, 32'h0BADC0DE,    0, 0, 32'h40,  1, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 0,0,0,0, 0, 0,               0, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 1,1,0,0, 0, 0,               0, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 0,1,0,0, 0, 0,               1, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 1,1,1,0, 0, 0,               1, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 0,0,1,0, 0, 0,               1, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 0,0,1,0, 1, 32'h11111111,    0, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 0,0,1,0, 0, 0,               1, 0, 32'h100, 0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D));
    tbl.push_back(v(0, 0,0,1,0, 1, 32'h22222222,    0, 0, 32'h100, 0, 1, 0, 32'h0BADC0DE, 32'h22222222));
    tbl.push_back(v(0, 0,1,0,0, 0, 0,               1, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'h22222222));
    tbl.push_back(v(0, 1,1,0,0, 1, 32'h33333333,    0, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'h22222222));
    tbl.push_back(v(0, 0,0,0,0, 0, 0,               0, 0, 32'h40,  0, 0, 0, 32'h0BADC0DE, 32'h22222222));
    tbl.push_back(v(0, 0,0,0,1, 0, 0,               0, 1, 32'h200, 0, 0, 0, 32'h0BADC0DE, 32'h22222222));
    tbl.push_back(v(1, 0,0,0,1, 0, 0,               0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0,0,0,1, 0, 0,               0, 1, 32'h200, 0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0,0,0,1, 1, 0,               0, 0, 32'h200, 0, 0, 1, 32'h0,        32'h0));
    tbl.push_back(v(0, 0,0,0,0, 0, 0,               0, 0, 32'h200, 0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0,0,1,0, 0, 0,               1, 0, 32'h100, 0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 1,0,1,0, 1, 32'h44444444,    0, 0, 32'h100, 0, 1, 0, 32'h0,        32'h44444444));
    tbl.push_back(v(0, 0,0,0,0, 0, 0,               0, 0, 32'h100, 0, 0, 0, 32'h0,        32'h44444444));

    foreach (tbl[k]) begin
      rst = tbl[k].r; flush = tbl[k].f; if_req = tbl[k].i; ld_req = tbl[k].l;
      st_req = tbl[k].s; mem_done = tbl[k].d; mem_r_data = tbl[k].rdat;
      tick();
      chk($sformatf("vec%0d_ctl", k), {27'b0, mem_read, mem_write, if_done, ld_done, st_done},
          {27'b0, tbl[k].rd, tbl[k].wr, tbl[k].ifd, tbl[k].ldd, tbl[k].std});
      chk($sformatf("vec%0d_addr", k), mem_addr, tbl[k].addr);
      chk($sformatf("vec%0d_if_data", k), if_data, tbl[k].ifdat);
      chk($sformatf("vec%0d_ld_data", k), ld_data, tbl[k].lddat);
      if (tbl[k].rd || tbl[k].wr)
        chk($sformatf("vec%0d_len", k), {30'b0, mem_len}, tbl[k].wr ? 32'h0 : 32'h3);
      if (tbl[k].wr)
        chk($sformatf("vec%0d_wdata", k), mem_w_data, 32'h12345678);
    end

    // Fetch held against alternating store/load traffic: fetch must win the
    // fifth arbitration, then its age restarts from zero.
    exp_g = '{32'h200, 32'h100, 32'h200, 32'h100, 32'h40, 32'h200, 32'h100};
    rst = 0; flush = 0; mem_done = 0; lat = 0; prev_act = 0;
    if_req = 1; ld_req = 1; st_req = 1;
    for (int n = 0; n < 200 && grants.size() < 7; n++) begin
      ctrl_step(0);
      tick();
      if ((mem_read || mem_write) && !prev_act) grants.push_back(mem_addr);
      prev_act = mem_read || mem_write;
    end
    if (grants.size() < 7) begin
      errors++; checks++;
      $display("FAIL starve_timeout actual=%0d grants required=7", grants.size());
    end
    foreach (grants[g]) if (g < 7) chk($sformatf("starve_grant%0d", g), grants[g], exp_g[g]);

    // Random traffic against the reference model.
    if_req = 0; ld_req = 0; st_req = 0; mem_done = 0; rst = 1; lat = 0;
    tick();
    rst = 0;
    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 14) == 0);
      if (if_done || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end else if ($urandom_range(0, 39) == 0) if_req = 0;
      if (ld_done || !ld_req) begin
        ld_req = ($urandom_range(0, 2) != 0); ld_addr = $urandom;
        ld_len = 2'($urandom); ld_signed = 1'($urandom);
      end else if ($urandom_range(0, 39) == 0) ld_req = 0;
      if (st_done || !st_req) begin
        st_req = ($urandom_range(0, 2) != 0); st_addr = $urandom;
        st_len = 2'($urandom); st_data = $urandom;
      end else if ($urandom_range(0, 39) == 0) st_req = 0;
      ctrl_step(3);
      tick();
      chk("rnd_ctl", {24'b0, mem_read, mem_write, mem_signed, mem_len, if_done, ld_done, st_done},
          {24'b0, e_read, e_write, e_signed, e_len, e_if_done, e_ld_done, e_st_done});
      chk("rnd_addr", mem_addr, e_addr);
      chk("rnd_wdata", mem_w_data, e_wdata);
      chk("rnd_if_data", if_data, e_if_data);
      chk("rnd_ld_data", ld_data, e_ld_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
